uart_rx_frame: RTL and testbench
================================

# uart_rx_frame

Asynchronous serial receiver for 8N1 frames, the downstream partner of the team's key-triggered UART transmitter. It samples a serial line (idle high, LSB first) at mid-bit using a `clk`-derived bit counter and delivers each byte with a one-cycle strobe. Framing errors are flagged rather than delivered. It consumes the transmitter's `line_tx` directly in loopback and the board RX pin in the system.

## Interface
- `CLK_PER_BIT`, default 2500: clock cycles per bit (50 MHz / 20 kbaud); even, >= 8.
- `HALF_BIT`, default `CLK_PER_BIT/2`: mid-bit sample offset.
- `clk`  input  1  system clock; every register on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `line_rx`  input  1  serial line, asynchronous to `clk`, idle 1.
- `data_rx`  output  8  last good byte; holds between frames.
- `rx_flag`  output  1  one-cycle pulse when `data_rx` has just been updated.
- `frame_err`  output  1  one-cycle pulse when a frame's stop bit sampled 0.
- `busy`  output  1  high in any state other than IDLE.

## Operation
- Reset values:
  - `data_rx` = 8'h00; `rx_flag`, `frame_err` and `busy` = 0.
  - Synchroniser flops = 1; state = IDLE; counters = 0.
- Input path: two-flop synchroniser (`s1`, `s2`) plus history flop `s3`. Falling edge `fall` = `s3 & ~s2`. The FSM uses only `s2`.
- Bit-timing counter `cnt` clears on every state entry and counts 0..`CLK_PER_BIT`-1.
- FSM transitions:
  - IDLE: on `fall` -> START.
  - START: at `cnt == HALF_BIT-1`, sample `s2`.
    - 1: glitch; -> IDLE with no output.
    - 0: -> DATA, `bit_idx` = 0, `cnt` cleared.
  - DATA: at `cnt == CLK_PER_BIT-1`, shift `s2` into `shreg` at position `bit_idx` (LSB first) and clear `cnt`. After `bit_idx` = 7 -> STOP.
  - STOP: at `cnt == CLK_PER_BIT-1`, sample `s2`.
    - 1: `data_rx` <= `shreg`, `rx_flag` pulses, -> IDLE.
    - 0: `frame_err` pulses, `data_rx` unchanged, -> BREAK.
  - BREAK: wait for `s2` == 1, then -> IDLE. This prevents a held-low line from re-triggering.
- `rx_flag` and `frame_err` are mutually exclusive and never last more than one cycle.
- Boundary conditions:
  - Back-to-back frames: IDLE is re-entered at mid-stop bit, so a start edge arriving one half-bit later is caught.
  - A `fall` in any non-IDLE state is ignored.
  - `rst_n` low mid-frame: immediate return to reset values. The partial byte is discarded and no flag is issued.
  - The line held low from reset: `s3` resets to 1, so one `fall` is seen. The frame completes with `frame_err`, then the block waits in BREAK.

## Timing
- Latency: `rx_flag` is high exactly 3 + `HALF_BIT` + 9·`CLK_PER_BIT` cycles after the first `clk` edge that samples `line_rx` = 0 for the start bit. This is 23753 cycles at defaults.
- `data_rx` changes in the same cycle that `rx_flag` is high.
- The sample point drifts at most 3 cycles from true mid-bit. Tolerated baud mismatch is about ±4 %.
- No downstream back-pressure: the consumer must take `data_rx` within one frame time (10·`CLK_PER_BIT` cycles).

## Structure
- Shared package `uart_pkg`:
  - the `CLK_PER_BIT` default;
  - the 8N1 frame constants (`UART_DATA_BITS` = 8, `UART_START` = 0, `UART_STOP` = 1);
  - the state encoding (IDLE, START, DATA, STOP, BREAK). The transmitter reuses these.
- Sub-module `uart_sync2`: the two-flop synchroniser, reset to 1. It is reused for every asynchronous input.
- The FSM, counters and shift register live in `uart_rx_frame` itself.

## Test plan
- Reset: hold `rst_n` = 0 with `line_rx` = 1 -> `data_rx` = 00, all pulses 0, `busy` = 0. Release -> outputs stay idle for 10 000 cycles.
- Single byte "J" (0x4A), driven at 2500 cycles/bit -> exactly one `rx_flag`, at cycle 23753 after the start edge, with `data_rx` = 0x4A and `frame_err` = 0.
- Back-to-back "J" then "1" (0x31) with one stop bit and no gap -> two `rx_flag` pulses 25 000 cycles apart; `data_rx` = 0x4A, then 0x31.
- Start glitch: line low for 1000 cycles (< `HALF_BIT`), then high -> no pulses; `busy` falls about 1253 cycles after the glitch.
- Framing error: frame 0x55 with stop bit 0, line held low 5000 further cycles -> one `frame_err` pulse, `data_rx` keeps its previous value, no `rx_flag`. The next valid frame 0xA3 then gives `rx_flag` with `data_rx` = 0xA3.
- Reset mid-frame: assert `rst_n` during bit 4 of 0xFF -> `busy` = 0 immediately, no flag. A subsequent 0x12 frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit period, 8N1 frame constants and the
// state encoding common to the receiver and the transmitter.
package uart_pkg;

    // 50 MHz system clock / 20 kbaud
    localparam int UART_CLK_PER_BIT = 2500;

    // 8N1 frame layout
    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_START     = 1'b0;
    localparam logic UART_STOP      = 1'b1;

    // Frame-level state encoding
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_e;

endpackage : uart_pkg

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous, idle-high input. Both stages
// reset to 1 so a released reset never manufactures a falling edge on an
// idle line.
module uart_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1_r;
    logic s2_r;

    // Metastability filter: two back-to-back capture stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r <= 1'b1;
            s2_r <= 1'b1;
        end else begin
            s1_r <= d;
            s2_r <= s1_r;
        end
    end

    assign q = s2_r;

endmodule : uart_sync2

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver. Detects the start edge on the synchronised line,
// samples every bit at its middle using a clk-derived bit counter and
// presents each good byte with a single-cycle rx_flag. A stop bit read as
// 0 raises frame_err instead and the receiver then parks in BREAK until
// the line returns high.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = UART_CLK_PER_BIT,
    parameter int HALF_BIT    = CLK_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       line_rx,
    output logic [7:0] data_rx,
    output logic       rx_flag,
    output logic       frame_err,
    output logic       busy
);

    localparam int               CW        = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0]    CNT_LAST  = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0]    CNT_HALF  = CW'(HALF_BIT - 1);
    localparam logic [2:0]       IDX_LAST  = 3'(UART_DATA_BITS - 1);

    logic          s2_s;
    logic          s3_r;
    logic          fall_s;

    uart_state_e   state_r;
    uart_state_e   state_s;
    logic [CW-1:0] cnt_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shreg_r;

    logic          cnt_clr_s;
    logic          shift_s;
    logic          idx_clr_s;
    logic          done_ok_s;
    logic          done_err_s;

    logic [7:0]    data_rx_r;
    logic          rx_flag_r;
    logic          frame_err_r;
    logic          busy_r;

    uart_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (line_rx),
        .q     (s2_s)
    );

    // History flop for falling-edge detection on the synchronised line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_r <= 1'b1;
        end else begin
            s3_r <= s2_s;
        end
    end

    assign fall_s = s3_r & ~s2_s;

    // Frame state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and per-cycle control decode
    always_comb begin
        state_s    = state_r;
        cnt_clr_s  = 1'b0;
        shift_s    = 1'b0;
        idx_clr_s  = 1'b0;
        done_ok_s  = 1'b0;
        done_err_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fall_s) begin
                    state_s   = ST_START;
                    cnt_clr_s = 1'b1;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == CNT_HALF) begin
                    cnt_clr_s = 1'b1;
                    if (s2_s == UART_START) begin
                        state_s   = ST_DATA;
                        idx_clr_s = 1'b1;
                    end else begin
                        // line went back high before mid-start: a glitch
                        state_s   = ST_IDLE;
                    end
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_clr_s = 1'b1;
                    shift_s   = 1'b1;
                    if (bit_idx_r == IDX_LAST) begin
                        state_s = ST_STOP;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_clr_s = 1'b1;
                    if (s2_s == UART_STOP) begin
                        // leave at mid-stop so a back-to-back start edge is caught
                        done_ok_s = 1'b1;
                        state_s   = ST_IDLE;
                    end else begin
                        done_err_s = 1'b1;
                        state_s    = ST_BREAK;
                    end
                end else begin
                    state_s = ST_STOP;
                end
            end
            ST_BREAK: begin
                // a line held low must not look like a fresh start bit
                if (s2_s == UART_STOP) begin
                    state_s   = ST_IDLE;
                    cnt_clr_s = 1'b1;
                end else begin
                    state_s   = ST_BREAK;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                cnt_clr_s = 1'b1;
            end
        endcase
    end

    // Bit-timing counter: zero on every state entry, idle while waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (cnt_clr_s || (state_r == ST_IDLE) || (state_r == ST_BREAK)) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Data-bit index and LSB-first shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx_r <= 3'd0;
            shreg_r   <= 8'h00;
        end else if (idx_clr_s) begin
            bit_idx_r <= 3'd0;
        end else if (shift_s) begin
            bit_idx_r          <= bit_idx_r + 3'd1;
            shreg_r[bit_idx_r] <= s2_s;
        end else begin
            bit_idx_r <= bit_idx_r;
            shreg_r   <= shreg_r;
        end
    end

    // Registered outputs: byte capture, completion strobes and busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_rx_r   <= 8'h00;
            rx_flag_r   <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            if (done_ok_s) begin
                data_rx_r <= shreg_r;
            end else begin
                data_rx_r <= data_rx_r;
            end
            rx_flag_r   <= done_ok_s;
            frame_err_r <= done_err_s;
            busy_r      <= (state_s != ST_IDLE);
        end
    end

    assign data_rx   = data_rx_r;
    assign rx_flag   = rx_flag_r;
    assign frame_err = frame_err_r;
    assign busy      = busy_r;

endmodule : uart_rx_frame

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame at a shortened bit period.
// Stimulus pushes the expected completion event (kind, byte, arrival cycle)
// before driving a frame; an independent monitor pops one entry per pulse.
module tb_uart_rx_frame;

    localparam int CPB = 16;
    localparam int HB  = 8;
    // 3 + HALF_BIT + 9*CLK_PER_BIT = 3 + 8 + 144
    localparam int LAT = 155;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
        int         t;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic       line_rx;
    logic [7:0] data_rx;
    logic       rx_flag;
    logic       frame_err;
    logic       busy;

    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    logic prev_pulse = 1'b0;
    ev_t sb[$];

    uart_rx_frame #(.CLK_PER_BIT(CPB), .HALF_BIT(HB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .line_rx   (line_rx),
        .data_rx   (data_rx),
        .rx_flag   (rx_flag),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic is_err, input logic [7:0] d, input int t);
        ev_t e;
        e.is_err = is_err;
        e.data   = d;
        e.t      = t;
        sb.push_back(e);
    endtask

    // one 8N1 frame, each bit held CPB cycles, starting at a negedge
    task automatic send(input logic [7:0] b, input logic stop_bit);
        logic bitv;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) bitv = 1'b0;
            else if (i == 9) bitv = stop_bit;
            else bitv = b[i-1];
            line_rx = bitv;
            repeat (CPB) @(negedge clk);
        end
    endtask

    // Monitor: every strobe must match the head of the scoreboard
    always @(negedge clk) begin
        ev_t e;
        if (rst_n && (rx_flag || frame_err)) begin
            chk("strobe_exclusive", int'(rx_flag & frame_err), 0);
            chk("strobe_single_cycle", int'(prev_pulse), 0);
            if (sb.size() == 0) begin
                chk("unexpected_strobe", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("strobe_kind_err", int'(frame_err), int'(e.is_err));
                chk("strobe_data_rx", int'(data_rx), int'(e.data));
                chk("strobe_cycle", cyc, e.t);
            end
        end
        prev_pulse = rx_flag | frame_err;
    end

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: run exceeded cycle budget at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int c0;
        int waited;
        rst_n   = 1'b0;
        line_rx = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset_data_rx", int'(data_rx), 8'h00);
        chk("reset_rx_flag", int'(rx_flag), 0);
        chk("reset_frame_err", int'(frame_err), 0);
        chk("reset_busy", int'(busy), 0);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        chk("idle_data_rx", int'(data_rx), 8'h00);

        // single byte 'J'
        push(1'b0, 8'h4A, cyc + LAT);
        send(8'h4A, 1'b1);
        repeat (2*CPB) @(negedge clk);
        chk("single_hold", int'(data_rx), 8'h4A);

        // back-to-back 'J' then '1', 10*CPB apart
        push(1'b0, 8'h4A, cyc + LAT);
        push(1'b0, 8'h31, cyc + 10*CPB + LAT);
        send(8'h4A, 1'b1);
        send(8'h31, 1'b1);
        repeat (2*CPB) @(negedge clk);
        chk("b2b_hold", int'(data_rx), 8'h31);

        // start glitch shorter than half a bit
        c0 = cyc;
        line_rx = 1'b0;
        repeat (4) @(negedge clk);
        line_rx = 1'b1;
        chk("glitch_busy_high", int'(busy), 1);
        waited = 0;
        while (busy && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("glitch_busy_fall_cycle", cyc, c0 + 3 + HB);
        repeat (2*CPB) @(negedge clk);
        chk("glitch_hold", int'(data_rx), 8'h31);

        // framing error: stop bit 0, line held low, then a good frame
        push(1'b1, 8'h31, cyc + LAT);
        send(8'h55, 1'b0);
        repeat (2*CPB) @(negedge clk);
        chk("break_busy", int'(busy), 1);
        line_rx = 1'b1;
        repeat (3*CPB) @(negedge clk);
        chk("ferr_hold", int'(data_rx), 8'h31);
        chk("ferr_busy_idle", int'(busy), 0);
        push(1'b0, 8'hA3, cyc + LAT);
        send(8'hA3, 1'b1);
        repeat (2*CPB) @(negedge clk);
        chk("after_ferr_data", int'(data_rx), 8'hA3);

        // reset during bit 4 of 0xFF
        line_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        line_rx = 1'b1;
        repeat (4*CPB + CPB/2) @(negedge clk);
        chk("midframe_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("midframe_busy_reset", int'(busy), 0);
        chk("midframe_data_reset", int'(data_rx), 8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10*CPB) @(negedge clk);
        chk("midframe_busy_after", int'(busy), 0);
        push(1'b0, 8'h12, cyc + LAT);
        send(8'h12, 1'b1);
        repeat (2*CPB) @(negedge clk);
        chk("after_reset_data", int'(data_rx), 8'h12);

        waited = 0;
        while (sb.size() != 0 && waited < 20*CPB) begin
            @(negedge clk);
            waited++;
        end
        chk("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_rx_frame
